// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester-side and FIFO-side signals of the write-port arbiter
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 4
);
  localparam int IW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            req_ack;
  logic [NUM_REQ-1:0]            grant;
  logic [IW-1:0]                 grant_id;
  logic                          busy;
  logic                          fifo_full;
  logic                          fifo_afull;
  logic                          fifo_wr_en;
  logic [DATA_WIDTH-1:0]         fifo_wr_data;
  modport master (
    input  req, req_data, req_last, fifo_full, fifo_afull,
    output req_ack, grant, grant_id, busy, fifo_wr_en, fifo_wr_data
  );
  modport slave (
    output req, req_data, req_last, fifo_full, fifo_afull,
    input  req_ack, grant, grant_id, busy, fifo_wr_en, fifo_wr_data
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one async-FIFO write port
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                wr_clk,
  input  logic                wr_rst,
  fifo_wr_arbiter_if.master   bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST) + 1;
  typedef enum logic {IDLE, BURST} state_t;
  state_t             r_state;
  logic [NUM_REQ-1:0] r_grant;
  logic [IW-1:0]      r_grant_id;
  logic [IW-1:0]      r_ptr;
  logic [CW-1:0]      r_cnt;
  logic [IW-1:0]      w_sel;
  logic [IW-1:0]      w_next_ptr;
  logic               w_sel_ok;
  logic               w_req_g;
  logic               w_wr_en;
  logic               w_end;
  // scan downward so the lowest circular offset from the pointer wins
  always_comb begin
    w_sel_ok = 1'b0;
    w_sel    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (bus.req[(int'(r_ptr) + k) % NUM_REQ]) begin
        w_sel_ok = 1'b1;
        w_sel    = IW'((int'(r_ptr) + k) % NUM_REQ);
      end
  end
  assign w_req_g    = bus.req[r_grant_id];
  assign w_wr_en    = !wr_rst && r_state == BURST && w_req_g && !bus.fifo_full;
  assign w_end      = !w_req_g || (w_wr_en && (bus.req_last[r_grant_id] || r_cnt == CW'(MAX_BURST - 1)));
  assign w_next_ptr = r_grant_id == IW'(NUM_REQ - 1) ? '0 : r_grant_id + 1'b1;
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_grant_id <= '0;
      r_cnt      <= '0;
      r_ptr      <= '0;
    end else if (r_state == IDLE) begin
      if (w_sel_ok && !bus.fifo_afull) begin
        r_state    <= BURST;
        r_grant    <= NUM_REQ'(1) << w_sel;
        r_grant_id <= w_sel;
        r_cnt      <= '0;
      end
    end else if (w_end) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_grant_id <= '0;
      r_cnt      <= '0;
      r_ptr      <= w_next_ptr;
    end else if (w_wr_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
  assign bus.grant        = r_grant;
  assign bus.grant_id     = r_grant_id;
  assign bus.busy         = r_state == BURST;
  assign bus.fifo_wr_en   = w_wr_en;
  assign bus.fifo_wr_data = bus.req_data[r_grant_id*DATA_WIDTH +: DATA_WIDTH];
  assign bus.req_ack      = w_wr_en ? NUM_REQ'(1) << r_grant_id : '0;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: queue-backed requesters feeding the arbiter, writes checked against a scoreboard
module tb_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int DW = 4;
  localparam int MB = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus();
  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .wr_clk(clk),
    .wr_rst(rst),
    .bus(bus)
  );
  int          n_cmp = 0;
  int          n_err = 0;
  logic [DW:0] src[NR][$];
  logic [31:0] exp_q[$];
  logic [31:0] hist;
  logic [NR-1:0] last_ack;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask
  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      bus.req[i]             = src[i].size() > 0;
      bus.req_data[i*DW+:DW] = src[i].size() > 0 ? src[i][0][DW-1:0] : '0;
      bus.req_last[i]        = src[i].size() > 0 && src[i][0][DW];
    end
  endtask
  task automatic load(input int id, input logic last, input logic [DW-1:0] d);
    src[id].push_back({last, d});
  endtask
  task automatic expect_wr(input int id, input logic [DW-1:0] d);
    exp_q.push_back(32'({2'(id), d}));
  endtask
  task automatic step();
    logic [31:0] e;
    @(negedge clk);
    hist     = {hist[30:0], bus.fifo_wr_en};
    last_ack = bus.req_ack;
    if (bus.fifo_wr_en) begin
      if (exp_q.size() == 0) check("unexpected_wr", 32'({bus.grant_id, bus.fifo_wr_data}), 32'hffff);
      else begin
        e = exp_q.pop_front();
        check("wr", 32'({bus.grant_id, bus.fifo_wr_data}), e);
        check("ack", 32'(bus.req_ack), 32'(1) << e[DW+1:DW]);
      end
    end else if (bus.req_ack != 0) check("ack_idle", 32'(bus.req_ack), 32'(0));
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++)
      if (last_ack[i] && src[i].size() > 0) src[i].delete(0);
    drive();
  endtask
  task automatic drain();
    for (int n = 0; n < 200 && exp_q.size() > 0; n++) step();
    check("drain", 32'(exp_q.size()), 32'(0));
    step();
  endtask
  task automatic do_reset();
    rst            = 1'b1;
    bus.fifo_full  = 1'b0;
    bus.fifo_afull = 1'b0;
    for (int i = 0; i < NR; i++) src[i].delete();
    exp_q.delete();
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst  = 1'b0;
    hist = '0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    do_reset();
    check("rst_grant", 32'(bus.grant), 32'(0));
    check("rst_grant_id", 32'(bus.grant_id), 32'(0));
    check("rst_busy", 32'(bus.busy), 32'(0));
    check("rst_wr_en", 32'(bus.fifo_wr_en), 32'(0));
    // single requester: 4-word burst, bubble, 2-word burst
    for (int j = 0; j < 6; j++) begin
      load(2, j == 5, 4'(j + 3));
      expect_wr(2, 4'(j + 3));
    end
    drive();
    for (int s = 0; s < 10; s++) begin
      step();
      if (s == 5) begin
        check("t1_grant_id", 32'(bus.grant_id), 32'(2));
        check("t1_busy", 32'(bus.busy), 32'(1));
      end
    end
    check("t1_pattern", 32'(hist[9:0]), 32'(10'b0111101100));
    check("t1_drain", 32'(exp_q.size()), 32'(0));
    // pointer now 3: requester 3 is served before requester 1
    load(1, 1'b1, 4'hA);
    load(3, 1'b1, 4'hB);
    expect_wr(3, 4'hB);
    expect_wr(1, 4'hA);
    drive();
    drain();
    // all four continuously active: rotation 0,1,2,3,0,...
    do_reset();
    for (int i = 0; i < NR; i++)
      for (int j = 0; j < 8; j++) load(i, 1'b0, 4'(i + j));
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NR; i++)
        for (int j = 4*k; j < 4*k + 4; j++) expect_wr(i, 4'(i + j));
    drive();
    drain();
    // full stall mid-burst
    do_reset();
    for (int j = 0; j < 4; j++) begin
      load(0, 1'b0, 4'(j + 8));
      expect_wr(0, 4'(j + 8));
    end
    drive();
    repeat (3) step();
    bus.fifo_full = 1'b1;
    for (int s = 0; s < 5; s++) begin
      step();
      if (s == 2) check("t3_grant_held", 32'(bus.grant), 32'(1));
    end
    bus.fifo_full = 1'b0;
    repeat (3) step();
    check("t3_pattern", 32'(hist[10:0]), 32'(11'b01100000110));
    check("t3_drain", 32'(exp_q.size()), 32'(0));
    // afull blocks a new grant
    do_reset();
    bus.fifo_afull = 1'b1;
    for (int i = 0; i < NR; i++) begin
      load(i, 1'b1, 4'(i + 12));
      expect_wr(i, 4'(i + 12));
    end
    drive();
    repeat (3) step();
    check("t4_no_grant", 32'(bus.grant), 32'(0));
    check("t4_no_wr", 32'(hist[2:0]), 32'(0));
    bus.fifo_afull = 1'b0;
    step();
    check("t4_grant0", 32'(bus.grant), 32'(1));
    drain();
    // requester 1 withdraws after one word; requester 2 is next
    do_reset();
    load(1, 1'b0, 4'h1);
    load(2, 1'b0, 4'h2);
    load(2, 1'b1, 4'h3);
    expect_wr(1, 4'h1);
    expect_wr(2, 4'h2);
    expect_wr(2, 4'h3);
    drive();
    repeat (3) step();
    check("t5_ended", 32'(bus.busy), 32'(0));
    load(1, 1'b1, 4'h4);
    expect_wr(1, 4'h4);
    drive();
    drain();
    // reset mid-burst of requester 2 after the pointer has moved to 2
    do_reset();
    load(1, 1'b1, 4'h5);
    expect_wr(1, 4'h5);
    drive();
    drain();
    for (int j = 0; j < 4; j++) load(2, 1'b0, 4'(j + 6));
    expect_wr(2, 4'h6);
    drive();
    repeat (2) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_rst_wr_en", 32'(hist[0]), 32'(0));
    check("t6_rst_ack", 32'(last_ack), 32'(0));
    check("t6_rst_grant", 32'(bus.grant), 32'(0));
    check("t6_rst_busy", 32'(bus.busy), 32'(0));
    load(0, 1'b1, 4'hE);
    load(1, 1'b1, 4'hF);
    expect_wr(0, 4'hE);
    expect_wr(1, 4'hF);
    expect_wr(2, 4'h7);
    expect_wr(2, 4'h8);
    expect_wr(2, 4'h9);
    drive();
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin burst arbiter that shares the single write port of the async FIFO between NUM_REQ requesters in the write-clock domain. A granted requester keeps the port for one burst, which lasts up to MAX_BURST words or until its last-word flag. The arbiter consumes the FIFO's full/afull status. It never presents a write while full is high and never opens a new burst while afull is high.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
DATA_WIDTH, 4, FIFO word width
MAX_BURST, 4, maximum words per grant (>=1); burst counter width = $clog2(MAX_BURST)+1

Ports:
wr_clk  input  1  FIFO write clock; the only clock
wr_rst  input  1  synchronous, active-high reset
req  input  NUM_REQ  per-requester "word available", level
req_data  input  NUM_REQ*DATA_WIDTH  word of requester i at [i*DATA_WIDTH +: DATA_WIDTH]
req_last  input  NUM_REQ  current word of requester i ends its packet
req_ack  output  NUM_REQ  one-hot; word of requester i written this cycle
grant  output  NUM_REQ  one-hot registered grant; all zero when idle
grant_id  output  $clog2(NUM_REQ)  index of granted requester; 0 when idle
busy  output  1  high while in BURST state
fifo_full  input  1  FIFO full flag
fifo_afull  input  1  FIFO almost-full flag
fifo_wr_en  output  1  FIFO write enable
fifo_wr_data  output  DATA_WIDTH  FIFO write data

Behaviour:
- Reset (wr_rst high at a wr_clk edge):
  - state=IDLE; grant=0, grant_id=0, busy=0; burst counter=0; rr pointer=0.
  - fifo_wr_en and req_ack are forced 0 combinationally while wr_rst is high.
  - A reset mid-burst abandons the burst. The word in the reset cycle is not written and not acked.
- State IDLE:
  - If any req bit is set and fifo_afull=0, select the first set req at or after the rr pointer, in circular order.
  - Next edge: grant/grant_id register the selection, busy=1, state=BURST, burst counter=0.
  - No write or ack occurs in IDLE.
- State BURST, granted index g:
  - fifo_wr_en = req[g] & ~fifo_full, combinational.
  - fifo_wr_data = req_data slice g, unconditionally.
  - req_ack[g] = fifo_wr_en; all other ack bits are 0.
  - Each write increments the burst counter.
- Burst ends at the edge following a write where req_last[g]=1 or the counter equals MAX_BURST-1.
  - It also ends at the edge of any cycle where req[g]=0 (requester withdrew).
  - On end: state=IDLE, grant=0, busy=0, rr pointer=(g+1) mod NUM_REQ.
- fifo_full=1 during BURST stalls the burst: grant is held, counter is held, no ack. Stalls have no timeout.
- fifo_afull affects only IDLE→BURST entry; an open burst continues past afull until full.
- Latency:
  - req seen in IDLE at edge t → grant visible after t. First write can occur in the cycle after t.
  - After a burst ends there is at least one IDLE cycle before the next grant, i.e. a one-cycle bubble per arbitration.
- Fairness: with all requesters continuously active, grants rotate 0,1,2,…,NUM_REQ-1,0. A requester waits at most NUM_REQ-1 bursts.
- req_last with MAX_BURST=1: every burst is exactly one word.
- Counters wrap-free: the counter never exceeds MAX_BURST-1.
- The rr pointer wraps modulo NUM_REQ; NUM_REQ that is not a power of two must be supported.

Test Plan:
- Single requester: req[2]=1 for 6 words, last on the 6th, MAX_BURST=4 → a write burst of 4 and then a burst of 2. Exactly one idle cycle separates them. grant_id=2 throughout; rr pointer=3 after each burst.
- All four req high continuously with no last → grant_id sequence 0,1,2,3,0. Each burst has 4 writes. fifo_wr_data matches the granted slice every write.
- fifo_full high for 5 cycles mid-burst after 2 words → fifo_wr_en=0 and req_ack=0 for those 5 cycles. The burst then resumes and finishes the remaining 2 words under the same grant.
- fifo_afull=1 in IDLE with req=4'b1111 → no grant while afull is high. Grant to requester 0 occurs on the edge after afull drops.
- Requester 1 drops req after 1 word of its burst → the burst ends at that edge. The next grant goes to requester 2 (if requesting), not to 1.
- wr_rst pulsed for one cycle mid-burst with a write pending → no write or ack in that cycle. Afterwards grant=0, busy=0, and the next grant goes to requester 0.
